// File: rtl/beep_pattern_gen.sv
// Parking-sensor beep sequencer: turns obstacle distance into a gated tone-step word for the codec.
// Define PITCH_SCALE_EN to raise the tone pitch as the obstacle gets closer.
module beep_pattern_gen #(
    parameter int CLK_HZ     = 18432000,
    parameter int TICK_HZ    = 1000,
    parameter int FAR_CM     = 150,
    parameter int NEAR_CM    = 20,
    parameter int MS_PER_CM  = 4,
    parameter int ON_MS      = 60,
    parameter int TONE_STEP  = 1200,
    parameter int TIMEOUT_MS = 500
) (
    input  logic        iCLK_18_4,
    input  logic        iRST_N,
    input  logic [8:0]  iDIST_CM,
    input  logic        iDIST_VALID,
    output logic [15:0] oSOUND,
    output logic        oBEEP,
    output logic        oFAULT
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(TIMEOUT_MS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_CONT = 2'd3
    } state_t;

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_s;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          fault_s;
    logic          fault_q;
    logic [8:0]    dist_q, dist_d;
    logic          zone_far_s, zone_near_s;
    logic [11:0]   period_s, period_q;
    logic [11:0]   cnt_q;
    state_t        state_q;
    logic          tone_on_s;
    logic          beep_q;
    logic [15:0]   sound_q;
    logic [15:0]   step_s;
    logic [15:0]   tone_s;

    assign fault_s     = (to_cnt_q == TW'(TIMEOUT_MS));
    assign zone_far_s  = (int'(dist_q) >= FAR_CM);
    assign zone_near_s = (int'(dist_q) <= NEAR_CM);
    assign period_s    = 12'(int'(dist_q) * MS_PER_CM);
    assign tone_on_s   = (state_q == ST_ON) || (state_q == ST_CONT);

    // Tick prescaler, distance latch and staleness timer next-state
    always_comb begin
        tick_s = (presc_q == PW'(DIV - 1));
        if (tick_s) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q + PW'(1);
        end
        if (iDIST_VALID) begin
            dist_d   = iDIST_CM;
            to_cnt_d = {TW{1'b0}};
        end else begin
            dist_d = dist_q;
            if (tick_s && !fault_s) begin
                to_cnt_d = to_cnt_q + TW'(1);
            end else begin
                to_cnt_d = to_cnt_q;
            end
        end
    end

    // Time base, distance and fault registers
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            presc_q  <= {PW{1'b0}};
            to_cnt_q <= {TW{1'b0}};
            dist_q   <= 9'(FAR_CM);
            fault_q  <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            to_cnt_q <= to_cnt_d;
            dist_q   <= dist_d;
            fault_q  <= (to_cnt_d == TW'(TIMEOUT_MS));
        end
    end

`ifdef PITCH_SCALE_EN
    logic [8:0]  pitch_diff_s;
    logic [16:0] pitch_sum_s;
    logic [15:0] step_q;

    // Closer obstacle gives a higher step word, saturated to 16 bits
    always_comb begin
        if (zone_far_s) begin
            pitch_diff_s = 9'd0;
        end else begin
            pitch_diff_s = 9'(FAR_CM) - dist_q;
        end
        pitch_sum_s = 17'(TONE_STEP) + {5'd0, pitch_diff_s, 3'd0};
        if (pitch_sum_s[16]) begin
            step_s = 16'hFFFF;
        end else begin
            step_s = pitch_sum_s[15:0];
        end
    end

    // Step is frozen for the length of a beep but tracks distance outside ON
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            step_q <= 16'd0;
        end else if (state_q != ST_ON) begin
            step_q <= step_s;
        end else begin
            step_q <= step_q;
        end
    end

    assign tone_s = step_q;
`else
    assign step_s = 16'(TONE_STEP);
    assign tone_s = step_s;
`endif

    // Beep sequencer with registered tone outputs
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 12'd0;
            period_q <= 12'd0;
            beep_q   <= 1'b0;
            sound_q  <= 16'd0;
        end else begin
            beep_q  <= tone_on_s;
            sound_q <= tone_on_s ? tone_s : 16'd0;
            if (fault_s) begin
                state_q <= ST_IDLE;
                cnt_q   <= 12'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q <= 12'd0;
                        if (zone_near_s) begin
                            state_q <= ST_CONT;
                        end else if (!zone_far_s) begin
                            state_q  <= ST_ON;
                            period_q <= period_s;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_ON: begin
                        if (zone_near_s) begin
                            state_q <= ST_CONT;
                            cnt_q   <= 12'd0;
                        end else if (tick_s && (cnt_q == 12'(ON_MS - 1))) begin
                            state_q <= ST_OFF;
                            cnt_q   <= 12'd0;
                        end else if (tick_s) begin
                            cnt_q <= cnt_q + 12'd1;
                        end else begin
                            cnt_q <= cnt_q;
                        end
                    end
                    ST_OFF: begin
                        if (zone_near_s) begin
                            state_q <= ST_CONT;
                            cnt_q   <= 12'd0;
                        end else if (tick_s && (cnt_q == (period_q - 12'(ON_MS) - 12'd1))) begin
                            cnt_q <= 12'd0;
                            if (zone_far_s) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q  <= ST_ON;
                                period_q <= period_s;
                            end
                        end else if (tick_s) begin
                            cnt_q <= cnt_q + 12'd1;
                        end else begin
                            cnt_q <= cnt_q;
                        end
                    end
                    ST_CONT: begin
                        cnt_q <= 12'd0;
                        if (zone_far_s) begin
                            state_q <= ST_IDLE;
                        end else if (!zone_near_s) begin
                            state_q  <= ST_ON;
                            period_q <= period_s;
                        end else begin
                            state_q <= ST_CONT;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 12'd0;
                    end
                endcase
            end
        end
    end

    assign oBEEP  = beep_q;
    assign oSOUND = sound_q;
    assign oFAULT = fault_q;

endmodule
